// File: rtl/uurisc_dbg_pkg.sv
// Shared debug-control types for the uurisc run controller.
package uurisc_dbg_pkg;

    // Host debug commands carried on cmd_op.
    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_HALT   = 3'd1,
        OP_STEP   = 3'd2,
        OP_RUN    = 3'd3,
        OP_RUN_N  = 3'd4,
        OP_SET_BP = 3'd5,
        OP_CLR_BP = 3'd6
    } cmd_op_t;

    // Why the core last stopped; held until the next halt.
    typedef enum logic [1:0] {
        HR_NONE       = 2'd0,
        HR_HOST       = 2'd1,
        HR_COUNT      = 2'd2,
        HR_BREAKPOINT = 2'd3
    } halt_reason_t;

    // Controller run state.
    typedef enum logic {
        ST_HALTED  = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_t;

endpackage

// File: rtl/exec_run_controller.sv
// Debug run/step/halt sequencer. Owns the core's run input and only ever
// stops the core on an instruction boundary (the cycle the core writes back).
module exec_run_controller
    import uurisc_dbg_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 16,
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [((ADDR_WIDTH > COUNT_WIDTH) ? ADDR_WIDTH : COUNT_WIDTH)-1:0] cmd_arg,
    output logic                    cmd_err,
    output logic                    core_run,
    input  logic                    core_wr,
    input  logic [ADDR_WIDTH-1:0]   core_pc,
    output logic                    halted,
    output logic [1:0]              halt_reason,
    output logic [RETIRE_WIDTH-1:0] retired
);

    run_state_t                state_q, state_d;
    logic                      bounded_q, bounded_d;
    logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic                      halt_pending_q, halt_pending_d;
    logic                      bp_en_q, bp_en_d;
    logic [ADDR_WIDTH-1:0]     bp_addr_q, bp_addr_d;
    halt_reason_t              halt_reason_q, halt_reason_d;
    logic [RETIRE_WIDTH-1:0]   retired_q, retired_d;
    logic                      cmd_err_q, cmd_err_d;

    logic running;
    logic boundary;
    logic bp_hit;
    logic cnt_done;
    logic stop;

    // Boundary detection and the combinational run gate. Run drops in the
    // write-back cycle of the last instruction so the core idles after it.
    // The breakpoint compares the PC the core is about to execute, so the
    // instruction at the breakpoint address is never started.
    always_comb begin
        running  = (state_q == ST_RUNNING);
        boundary = running & core_wr;
        bp_hit   = bp_en_q & (core_pc == bp_addr_q);
        cnt_done = bounded_q & (remaining_q == COUNT_WIDTH'(1));
        stop     = bp_hit | cnt_done | halt_pending_q;
        core_run = running & ~(core_wr & stop);
    end

    // Next-state logic: boundary bookkeeping first, then host commands.
    always_comb begin
        state_d        = state_q;
        bounded_d      = bounded_q;
        remaining_d    = remaining_q;
        halt_pending_d = halt_pending_q;
        bp_en_d        = bp_en_q;
        bp_addr_d      = bp_addr_q;
        halt_reason_d  = halt_reason_q;
        retired_d      = retired_q;
        cmd_err_d      = 1'b0;

        if (boundary) begin
            retired_d = retired_q + RETIRE_WIDTH'(1);
            if (bounded_q) begin
                remaining_d = remaining_q - COUNT_WIDTH'(1);
            end
            if (stop) begin
                state_d        = ST_HALTED;
                bounded_d      = 1'b0;
                halt_pending_d = 1'b0;
                if (bp_hit) begin
                    halt_reason_d = HR_BREAKPOINT;
                end else if (cnt_done) begin
                    halt_reason_d = HR_COUNT;
                end else begin
                    halt_reason_d = HR_HOST;
                end
            end
        end

        if (cmd_valid) begin
            unique case (cmd_op_t'(cmd_op))
                OP_HALT: begin
                    if (running && !(boundary && stop)) begin
                        halt_pending_d = 1'b1;
                    end
                end
                OP_STEP: begin
                    if (running) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d     = ST_RUNNING;
                        bounded_d   = 1'b1;
                        remaining_d = COUNT_WIDTH'(1);
                    end
                end
                OP_RUN: begin
                    if (running) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d   = ST_RUNNING;
                        bounded_d = 1'b0;
                    end
                end
                OP_RUN_N: begin
                    if (running) begin
                        cmd_err_d = 1'b1;
                    end else if (cmd_arg[COUNT_WIDTH-1:0] != '0) begin
                        state_d     = ST_RUNNING;
                        bounded_d   = 1'b1;
                        remaining_d = cmd_arg[COUNT_WIDTH-1:0];
                    end
                end
                OP_SET_BP: begin
                    bp_addr_d = cmd_arg[ADDR_WIDTH-1:0];
                    bp_en_d   = 1'b1;
                end
                OP_CLR_BP: begin
                    bp_addr_d = cmd_arg[ADDR_WIDTH-1:0];
                    bp_en_d   = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous reset shared with the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_HALTED;
            bounded_q      <= 1'b0;
            remaining_q    <= '0;
            halt_pending_q <= 1'b0;
            bp_en_q        <= 1'b0;
            bp_addr_q      <= '0;
            halt_reason_q  <= HR_NONE;
            retired_q      <= '0;
            cmd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bounded_q      <= bounded_d;
            remaining_q    <= remaining_d;
            halt_pending_q <= halt_pending_d;
            bp_en_q        <= bp_en_d;
            bp_addr_q      <= bp_addr_d;
            halt_reason_q  <= halt_reason_d;
            retired_q      <= retired_d;
            cmd_err_q      <= cmd_err_d;
        end
    end

    assign cmd_ready   = 1'b1;
    assign cmd_err     = cmd_err_q;
    assign halted      = (state_q == ST_HALTED);
    assign halt_reason = halt_reason_q;
    assign retired     = retired_q;

endmodule
